matrix_weight_server: RTL

- Responder end of the matrix SRAM interface that `matvec_multiplier`-style initiators use to fetch weight chunks.
- Stores a MAX_ROWS×MAX_COLS matrix of Q2.14 weights, preloaded through a chunked write port.
- Answers each single-cycle read request with BANDWIDTH consecutive words after a fixed latency, plus a one-cycle ready pulse.
- Sits between the weight-load path and the matrix-vector datapath.

---
 rtl/matrix_weight_server_if.sv | 27 ++
 rtl/matrix_weight_server.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/matrix_weight_server_if.sv
// Bus bundle between a matvec-style initiator / weight loader and matrix_weight_server.
interface matrix_weight_server_if #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BANDWIDTH  = 16
);
  logic                         matrix_enable;
  logic [ADDR_W-1:0]            matrix_addr;
  logic signed [DATA_WIDTH-1:0] matrix_data [BANDWIDTH];
  logic                         matrix_ready;
  logic                         load_write_enable;
  logic [ADDR_W-1:0]            load_addr;
  logic signed [DATA_WIDTH-1:0] load_data [BANDWIDTH];
  logic                         busy;
  logic                         req_overrun;
  logic                         addr_error;

  modport slave (
    input  matrix_enable, matrix_addr, load_write_enable, load_addr, load_data,
    output matrix_data, matrix_ready, busy, req_overrun, addr_error
  );

  modport master (
    output matrix_enable, matrix_addr, load_write_enable, load_addr, load_data,
    input  matrix_data, matrix_ready, busy, req_overrun, addr_error
  );
endinterface

// File: rtl/matrix_weight_server.sv
// Weight SRAM responder: chunked loads, fixed-latency chunked reads with one-cycle ready pulse.
// Optional lane bounds checking (zero-fill / drop + sticky addr_error) via MATRIX_SERVER_BOUNDS_CHECK_EN.
module matrix_weight_server #(
  parameter int unsigned MAX_ROWS     = 64,
  parameter int unsigned MAX_COLS     = 64,
  parameter int unsigned BANDWIDTH    = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_weight_server_if.slave  bus
);
  localparam int unsigned DEPTH  = MAX_ROWS * MAX_COLS;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(READ_LATENCY + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef logic signed [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_W:0]              lane_t;

  word_t             mem [DEPTH];
  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic [ADDR_W-1:0] wr_idx [BANDWIDTH];
  logic [ADDR_W-1:0] rd_idx [BANDWIDTH];
  word_t             rd_chunk [BANDWIDTH];
  word_t             exit_data [BANDWIDTH];
  logic              exit_valid;

  function automatic lane_t lane_sum(logic [ADDR_W-1:0] base, int unsigned i);
    return {1'b0, base} + lane_t'(i);
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_idx(lane_t s);
    lane_t w;
    w = (s >= lane_t'(DEPTH)) ? s - lane_t'(DEPTH) : s;
    return w[ADDR_W-1:0];
  endfunction

  assign bus.busy = (state == WAIT);
  assign accept   = bus.matrix_enable && (state == IDLE);

`ifdef MATRIX_SERVER_BOUNDS_CHECK_EN
  logic [BANDWIDTH-1:0] wr_ok;
  logic [BANDWIDTH-1:0] rd_ok;
`endif

  always_comb begin
    for (int unsigned i = 0; i < BANDWIDTH; i++) begin
      wr_idx[i] = wrap_idx(lane_sum(bus.load_addr, i));
      rd_idx[i] = wrap_idx(lane_sum(bus.matrix_addr, i));
`ifdef MATRIX_SERVER_BOUNDS_CHECK_EN
      wr_ok[i]    = lane_sum(bus.load_addr, i) < lane_t'(DEPTH);
      rd_ok[i]    = lane_sum(bus.matrix_addr, i) < lane_t'(DEPTH);
      rd_chunk[i] = rd_ok[i] ? mem[rd_idx[i]] : '0;
`else
      rd_chunk[i] = mem[rd_idx[i]];
`endif
    end
  end

  // Memory is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (bus.load_write_enable) begin
      for (int unsigned i = 0; i < BANDWIDTH; i++) begin
`ifdef MATRIX_SERVER_BOUNDS_CHECK_EN
        if (wr_ok[i]) mem[wr_idx[i]] <= bus.load_data[i];
`else
        mem[wr_idx[i]] <= bus.load_data[i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.req_overrun <= 1'b0;
    end else begin
      if (bus.matrix_enable && state == WAIT) bus.req_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (accept && READ_LATENCY > 1) begin
            state <= WAIT;
            cnt   <= CNT_W'(READ_LATENCY - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 is captured at acceptance; the output register acts as the final stage,
  // so only READ_LATENCY-1 internal stages exist (none for READ_LATENCY=1).
  if (READ_LATENCY > 1) begin : g_pipe
    localparam int unsigned STAGES = READ_LATENCY - 1;
    word_t             pipe_data [STAGES][BANDWIDTH];
    logic [STAGES-1:0] pipe_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= accept;
        for (int unsigned k = 1; k < STAGES; k++) pipe_valid[k] <= pipe_valid[k-1];
      end
      pipe_data[0] <= rd_chunk;
      for (int unsigned k = 1; k < STAGES; k++) pipe_data[k] <= pipe_data[k-1];
    end

    assign exit_valid = pipe_valid[STAGES-1];
    assign exit_data  = pipe_data[STAGES-1];
  end else begin : g_direct
    assign exit_valid = accept;
    assign exit_data  = rd_chunk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.matrix_ready <= 1'b0;
      for (int unsigned i = 0; i < BANDWIDTH; i++) bus.matrix_data[i] <= '0;
    end else begin
      bus.matrix_ready <= exit_valid;
      if (exit_valid) bus.matrix_data <= exit_data;
    end
  end

`ifdef MATRIX_SERVER_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.addr_error <= 1'b0;
    end else if ((accept && !(&rd_ok)) || (bus.load_write_enable && !(&wr_ok))) begin
      bus.addr_error <= 1'b1;
    end
  end
`else
  assign bus.addr_error = 1'b0;
`endif

endmodule
